gc_cmd_responder: RTL and testbench

Parametrised command responder for the GameCube controller link. It sits between the one-wire GC interface and the button/analog front end. It decodes host commands (ID, poll, origin, calibrate) and builds a left-justified response buffer. Compared with the previous handler, it adds a stored calibration origin with a need-origin status bit, 8-bit analog triggers, and an acknowledge-based CMD_DONE handshake with a timeout. It also keeps a garbage-command counter.

---
 rtl/gc_pkg.sv | 34 +++
 rtl/gc_analog_packer.sv | 31 +++
 rtl/gc_cmd_responder.sv | 204 ++++++++++++++++++++
 tb/tb_gc_cmd_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared constants, state type and helpers for the GameCube command responder.
package gc_pkg;

    localparam logic [7:0] GC_CMD_ID     = 8'h00;
    localparam logic [7:0] GC_CMD_RESET  = 8'hFF;
    localparam logic [7:0] GC_CMD_POLL   = 8'h40;
    localparam logic [7:0] GC_CMD_ORIGIN = 8'h41;
    localparam logic [7:0] GC_CMD_CALIB  = 8'h42;

    localparam logic [23:0] GC_ID_DEFAULT = 24'h090030;

    localparam logic [7:0] GC_STICK_CENTRE = 8'h80;
    localparam logic [7:0] GC_TRIGGER_REST = 8'h00;
    // Origin layout: JX, JY, CX, CY, L, R.
    localparam logic [47:0] GC_ORIGIN_DEFAULT = {{4{GC_STICK_CENTRE}}, {2{GC_TRIGGER_REST}}};

    localparam int         GC_RESP_WIDTH  = 80;
    localparam logic [7:0] GC_BITS_ID     = 8'd24;
    localparam logic [7:0] GC_BITS_SHORT  = 8'd64;
    localparam logic [7:0] GC_BITS_ORIGIN = 8'd80;

    typedef enum logic [1:0] {
        GC_ST_IDLE    = 2'd0,
        GC_ST_DECODE  = 2'd1,
        GC_ST_RESPOND = 2'd2
    } gc_state_e;

    function automatic logic [7:0] gc_sat_add(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/gc_analog_packer.sv
// Maps the poll analog mode onto the four trailing response bytes (B4..B7).
module gc_analog_packer
    import gc_pkg::*;
(
    input  logic [7:0]  mode,
    input  logic [7:0]  c_stick_x,
    input  logic [7:0]  c_stick_y,
    input  logic [7:0]  l_analog,
    input  logic [7:0]  r_analog,
    output logic [31:0] analog_bytes
);

    always_comb begin
        analog_bytes = '0;
        case (mode)
            8'd0, 8'd5, 8'd6, 8'd7:
                analog_bytes = {c_stick_x, c_stick_y, l_analog[7:4], r_analog[7:4], 8'h00};
            8'd1:
                analog_bytes = {c_stick_x[7:4], c_stick_y[7:4], l_analog, r_analog, 8'h00};
            8'd2:
                analog_bytes = {c_stick_x[7:4], c_stick_y[7:4], l_analog[7:4], r_analog[7:4], 16'h0000};
            8'd3:
                analog_bytes = {c_stick_x, c_stick_y, l_analog, r_analog};
            8'd4:
                analog_bytes = {c_stick_x, c_stick_y, 16'h0000};
            default:
                analog_bytes = '0;
        endcase
    end

endmodule

// File: rtl/gc_cmd_responder.sv
// GameCube controller command responder: decodes host commands into a held, left-justified response.
// Define GC_ORIGIN_CAPTURE_EN to let calibrate (0x42) latch live stick/trigger positions as the origin.
//
// state    | meaning
// IDLE     | waiting for NEW_COMMAND
// DECODE   | live inputs snapshotted, response registered
// RESPOND  | CMD_DONE held until TX_DONE or hold timer expiry
module gc_cmd_responder
    import gc_pkg::*;
#(
    parameter int          TX_BUFFER_WIDTH = 80,
    parameter logic [23:0] ID_VECTOR       = GC_ID_DEFAULT,
    parameter int          DONE_TIMEOUT    = 4000
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [23:0]                COMMAND,
    input  logic [1:0]                 CMD_BYTES,
    input  logic                       NEW_COMMAND,
    input  logic                       TX_DONE,
    input  logic [15:0]                BUTTONS,
    input  logic [7:0]                 J_STICK_X,
    input  logic [7:0]                 J_STICK_Y,
    input  logic [7:0]                 C_STICK_X,
    input  logic [7:0]                 C_STICK_Y,
    input  logic [7:0]                 L_ANALOG,
    input  logic [7:0]                 R_ANALOG,
    output logic [TX_BUFFER_WIDTH-1:0] TX_BUFFER,
    output logic [7:0]                 TX_BIT_TOTAL,
    output logic                       CMD_DONE,
    output logic [1:0]                 RUMBLE,
    output logic                       NEED_ORIGIN,
    output logic [7:0]                 ERR_COUNT
);

    localparam int HOLD_W = $clog2(DONE_TIMEOUT + 1);

    gc_state_e state_q, state_d;

    logic [7:0]                 op_q;
    logic [7:0]                 mode_q;
    logic [1:0]                 rumble_cmd_q;
    logic [1:0]                 bytes_q;
    logic [HOLD_W-1:0]          hold_q;
    logic                       hold_tc;

    logic [TX_BUFFER_WIDTH-1:0] tx_buffer_q;
    logic [7:0]                 tx_bit_total_q;
    logic                       cmd_done_q;
    logic [1:0]                 rumble_q;
    logic                       need_origin_q;
    logic [7:0]                 err_count_q;

    logic                       is_id;
    logic                       is_poll;
    logic                       is_origin;
    logic                       is_bad;
    logic [7:0]                 byte0;
    logic [7:0]                 byte1;
    logic [31:0]                analog_bytes;
    logic [47:0]                origin_now;
    logic [GC_RESP_WIDTH-1:0]   resp;
    logic [7:0]                 resp_bits;
    logic [TX_BUFFER_WIDTH-1:0] resp_full;
    logic                       drop_cmd;
    logic                       bad_cmd;
    logic [1:0]                 err_inc;
    logic                       unused_inputs;

    // Rumble-field padding and the fixed/unused button positions carry no information.
    assign unused_inputs = ^{COMMAND[7:2], BUTTONS[15:13], BUTTONS[7]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= GC_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign hold_tc = (hold_q == HOLD_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            GC_ST_IDLE:    if (NEW_COMMAND) state_d = GC_ST_DECODE;
            GC_ST_DECODE:  state_d = GC_ST_RESPOND;
            GC_ST_RESPOND: if (TX_DONE || hold_tc) state_d = GC_ST_IDLE;
            default:       state_d = GC_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q         <= '0;
            mode_q       <= '0;
            rumble_cmd_q <= '0;
            bytes_q      <= '0;
        end else if (state_q == GC_ST_IDLE && NEW_COMMAND) begin
            op_q         <= COMMAND[23:16];
            mode_q       <= COMMAND[15:8];
            rumble_cmd_q <= COMMAND[1:0];
            bytes_q      <= CMD_BYTES;
        end
    end

    always_comb begin
        is_id     = (op_q == GC_CMD_ID) || (op_q == GC_CMD_RESET);
        is_poll   = (op_q == GC_CMD_POLL) && (bytes_q == 2'd3);
        is_origin = (op_q == GC_CMD_ORIGIN) || (op_q == GC_CMD_CALIB);
        is_bad    = !(is_id || is_poll || is_origin);
    end

    assign byte0 = {2'b00, need_origin_q, BUTTONS[12:8]};
    assign byte1 = {1'b1, BUTTONS[6:0]};

    gc_analog_packer u_analog_packer (
        .mode         (mode_q),
        .c_stick_x    (C_STICK_X),
        .c_stick_y    (C_STICK_Y),
        .l_analog     (L_ANALOG),
        .r_analog     (R_ANALOG),
        .analog_bytes (analog_bytes)
    );

`ifdef GC_ORIGIN_CAPTURE_EN
    logic [47:0] origin_q;
    logic [47:0] live_analog;

    assign live_analog = {J_STICK_X, J_STICK_Y, C_STICK_X, C_STICK_Y, L_ANALOG, R_ANALOG};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            origin_q <= GC_ORIGIN_DEFAULT;
        end else if (state_q == GC_ST_DECODE && op_q == GC_CMD_CALIB) begin
            origin_q <= live_analog;
        end
    end

    // Calibrate reports the origin it is capturing in the same DECODE cycle.
    assign origin_now = (op_q == GC_CMD_CALIB) ? live_analog : origin_q;
`else
    assign origin_now = GC_ORIGIN_DEFAULT;
`endif

    always_comb begin
        resp      = '0;
        resp_bits = GC_BITS_SHORT;
        if (is_id) begin
            resp[GC_RESP_WIDTH-1 -: 24] = ID_VECTOR;
            resp_bits                   = GC_BITS_ID;
        end else if (is_poll) begin
            resp[GC_RESP_WIDTH-1 -: 64] = {byte0, byte1, J_STICK_X, J_STICK_Y, analog_bytes};
        end else if (is_origin) begin
            resp      = {byte0, byte1, origin_now, 16'h0000};
            resp_bits = GC_BITS_ORIGIN;
        end
        resp_full = '0;
        resp_full[TX_BUFFER_WIDTH-1 -: GC_RESP_WIDTH] = resp;
    end

    // A rejected opcode and a dropped strobe can land in the same cycle.
    assign drop_cmd = NEW_COMMAND && (state_q != GC_ST_IDLE);
    assign bad_cmd  = (state_q == GC_ST_DECODE) && is_bad;
    assign err_inc  = {1'b0, drop_cmd} + {1'b0, bad_cmd};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_buffer_q    <= '0;
            tx_bit_total_q <= '0;
            cmd_done_q     <= 1'b0;
            rumble_q       <= '0;
            need_origin_q  <= 1'b1;
            err_count_q    <= '0;
            hold_q         <= '0;
        end else begin
            err_count_q <= gc_sat_add(err_count_q, err_inc);
            case (state_q)
                GC_ST_DECODE: begin
                    tx_buffer_q    <= resp_full;
                    tx_bit_total_q <= resp_bits;
                    cmd_done_q     <= 1'b1;
                    hold_q         <= HOLD_W'(DONE_TIMEOUT);
                    if (is_poll) rumble_q <= rumble_cmd_q;
                    if (is_origin) need_origin_q <= 1'b0;
                end
                GC_ST_RESPOND: begin
                    hold_q <= hold_q - HOLD_W'(1);
                    if (TX_DONE || hold_tc) cmd_done_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign TX_BUFFER    = tx_buffer_q;
    assign TX_BIT_TOTAL = tx_bit_total_q;
    assign CMD_DONE     = cmd_done_q;
    assign RUMBLE       = rumble_q;
    assign NEED_ORIGIN  = need_origin_q;
    assign ERR_COUNT    = err_count_q;

endmodule

// File: tb/tb_gc_cmd_responder.sv
// Self-checking bench for gc_cmd_responder: directed vector table, corner sequences, random vs. model.
module tb_gc_cmd_responder;

    localparam int W   = 96;
    localparam int TMO = 8;

`ifdef GC_ORIGIN_CAPTURE_EN
    localparam logic [79:0] EXP_CAL = 80'h0080_7071_7273_7475_0000;
`else
    localparam logic [79:0] EXP_CAL = 80'h0080_8080_8080_0000_0000;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [23:0]   COMMAND = '0;
    logic [1:0]    CMD_BYTES = '0;
    logic          NEW_COMMAND = 1'b0;
    logic          TX_DONE = 1'b0;
    logic [15:0]   BUTTONS = '0;
    logic [7:0]    J_STICK_X = '0, J_STICK_Y = '0, C_STICK_X = '0, C_STICK_Y = '0;
    logic [7:0]    L_ANALOG = '0, R_ANALOG = '0;
    logic [W-1:0]  TX_BUFFER;
    logic [7:0]    TX_BIT_TOTAL;
    logic          CMD_DONE;
    logic [1:0]    RUMBLE;
    logic          NEED_ORIGIN;
    logic [7:0]    ERR_COUNT;

    gc_cmd_responder #(
        .TX_BUFFER_WIDTH (W),
        .ID_VECTOR       (24'h090030),
        .DONE_TIMEOUT    (TMO)
    ) dut (
        .CLK (CLK), .RESET (RESET), .COMMAND (COMMAND), .CMD_BYTES (CMD_BYTES),
        .NEW_COMMAND (NEW_COMMAND), .TX_DONE (TX_DONE), .BUTTONS (BUTTONS),
        .J_STICK_X (J_STICK_X), .J_STICK_Y (J_STICK_Y), .C_STICK_X (C_STICK_X),
        .C_STICK_Y (C_STICK_Y), .L_ANALOG (L_ANALOG), .R_ANALOG (R_ANALOG),
        .TX_BUFFER (TX_BUFFER), .TX_BIT_TOTAL (TX_BIT_TOTAL), .CMD_DONE (CMD_DONE),
        .RUMBLE (RUMBLE), .NEED_ORIGIN (NEED_ORIGIN), .ERR_COUNT (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] cmd;
        logic [1:0]  nb;
        logic [15:0] btn;
        logic [7:0]  jx, jy, cx, cy, lt, rt;
        logic [79:0] resp;
        logic [7:0]  bits;
        logic [1:0]  rum;
        logic        need;
        logic [7:0]  err;
    } vec_t;

    vec_t vt [0:14];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic       m_need;
    logic [7:0] m_err;
    logic [1:0] m_rum;
    logic [7:0] m_org [0:5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        NEW_COMMAND = 1'b0;
        TX_DONE     = 1'b0;
        RESET       = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic set_inputs(input logic [15:0] btn, input logic [7:0] jx, jy, cx, cy, lt, rt);
        BUTTONS = btn; J_STICK_X = jx; J_STICK_Y = jy;
        C_STICK_X = cx; C_STICK_Y = cy; L_ANALOG = lt; R_ANALOG = rt;
    endtask

    // Returns two cycles after the strobe, when the response must be visible.
    task automatic issue(input logic [23:0] cmd, input logic [1:0] nb);
        COMMAND = cmd; CMD_BYTES = nb; NEW_COMMAND = 1'b1;
        step();
        NEW_COMMAND = 1'b0;
        step();
    endtask

    task automatic release_tx();
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
    endtask

    // Counts cycles CMD_DONE is high; TX_DONE in hold cycle k, NEW_COMMAND in hold cycle j (0 = none).
    task automatic hold_phase(input int k, input int j, output int cnt);
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (CMD_DONE !== 1'b1) break;
            cnt++;
            TX_DONE     = (c == k);
            NEW_COMMAND = (c == j);
            step();
            TX_DONE     = 1'b0;
            NEW_COMMAND = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_need = 1'b1;
        m_err  = 8'd0;
        m_rum  = 2'd0;
        for (int i = 0; i < 4; i++) m_org[i] = 8'h80;
        m_org[4] = 8'h00;
        m_org[5] = 8'h00;
    endtask

    task automatic model_apply(input logic [23:0] cmd, input logic [1:0] nb, input logic [15:0] btn,
                               input logic [7:0] jx, jy, cx, cy, lt, rt,
                               output logic [79:0] resp, output logic [7:0] bits);
        logic [7:0] q [$];
        logic [7:0] op, mode, b0, b1;
        op   = cmd[23:16];
        mode = cmd[15:8];
        b0   = {2'b00, m_need, btn[12], btn[11], btn[10], btn[9], btn[8]};
        b1   = {1'b1, btn[6], btn[5], btn[4], btn[3], btn[2], btn[1], btn[0]};
        q.delete();
        if (op == 8'h00 || op == 8'hFF) begin
            q.push_back(8'h09); q.push_back(8'h00); q.push_back(8'h30);
            bits = 8'd24;
        end else if (op == 8'h40 && nb == 2'd3) begin
            q.push_back(b0); q.push_back(b1); q.push_back(jx); q.push_back(jy);
            case (mode)
                8'd0, 8'd5, 8'd6, 8'd7: begin
                    q.push_back(cx); q.push_back(cy); q.push_back({lt[7:4], rt[7:4]}); q.push_back(8'h00);
                end
                8'd1: begin
                    q.push_back({cx[7:4], cy[7:4]}); q.push_back(lt); q.push_back(rt); q.push_back(8'h00);
                end
                8'd2: begin
                    q.push_back({cx[7:4], cy[7:4]}); q.push_back({lt[7:4], rt[7:4]});
                end
                8'd3: begin
                    q.push_back(cx); q.push_back(cy); q.push_back(lt); q.push_back(rt);
                end
                8'd4: begin
                    q.push_back(cx); q.push_back(cy);
                end
                default: begin
                end
            endcase
            bits  = 8'd64;
            m_rum = cmd[1:0];
        end else if (op == 8'h41 || op == 8'h42) begin
`ifdef GC_ORIGIN_CAPTURE_EN
            if (op == 8'h42) begin
                m_org[0] = jx; m_org[1] = jy; m_org[2] = cx; m_org[3] = cy; m_org[4] = lt; m_org[5] = rt;
            end
`endif
            q.push_back(b0); q.push_back(b1);
            for (int i = 0; i < 6; i++) q.push_back(m_org[i]);
            bits   = 8'd80;
            m_need = 1'b0;
        end else begin
            bits = 8'd64;
            if (m_err != 8'd255) m_err++;
        end
        resp = '0;
        for (int i = 0; i < q.size(); i++) resp[79 - 8*i -: 8] = q[i];
    endtask

    initial begin
        int cnt, r, k, j, lim;
        logic [7:0]  op, mode, jx, jy, cx, cy, lt, rt;
        logic [1:0]  nb;
        logic [15:0] btn;
        logic [23:0] cmd;
        logic [79:0] eresp;
        logic [7:0]  ebits;

        vt[0]  = '{24'h000000, 2'd1, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, {24'h090030, 56'h0}, 8'd24, 2'd0, 1'b1, 8'd0};
        vt[1]  = '{24'hFF0000, 2'd1, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, {24'h090030, 56'h0}, 8'd24, 2'd0, 1'b1, 8'd0};
        vt[2]  = '{24'h400301, 2'd3, 16'h0100, 8'h90, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h20, {64'h2180_9011_2233_C020, 16'h0}, 8'd64, 2'd1, 1'b1, 8'd0};
        vt[3]  = '{24'h400002, 2'd3, 16'h1011, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAB, 8'hCD, {64'h3091_0102_0304_AC00, 16'h0}, 8'd64, 2'd2, 1'b1, 8'd0};
        vt[4]  = '{24'h400100, 2'd3, 16'hE080, 8'h10, 8'h20, 8'h3F, 8'h4E, 8'h55, 8'h66, {64'h2080_1020_3455_6600, 16'h0}, 8'd64, 2'd0, 1'b1, 8'd0};
        vt[5]  = '{24'h400203, 2'd3, 16'h0840, 8'hFF, 8'h00, 8'h9A, 8'hBC, 8'hDE, 8'hF0, {64'h28C0_FF00_9BDF_0000, 16'h0}, 8'd64, 2'd3, 1'b1, 8'd0};
        vt[6]  = '{24'h400401, 2'd3, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, {64'h2080_1234_5678_0000, 16'h0}, 8'd64, 2'd1, 1'b1, 8'd0};
        vt[7]  = '{24'h400900, 2'd3, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, {64'h2080_1234_0000_0000, 16'h0}, 8'd64, 2'd0, 1'b1, 8'd0};
        vt[8]  = '{24'h400602, 2'd3, 16'h0000, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, {64'h2080_1234_5678_9B00, 16'h0}, 8'd64, 2'd2, 1'b1, 8'd0};
        vt[9]  = '{24'h410000, 2'd1, 16'h0200, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 80'h2280_8080_8080_0000_0000, 8'd80, 2'd2, 1'b0, 8'd0};
        vt[10] = '{24'h400302, 2'd3, 16'h0100, 8'h90, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h20, {64'h0180_9011_2233_C020, 16'h0}, 8'd64, 2'd2, 1'b0, 8'd0};
        vt[11] = '{24'h550000, 2'd1, 16'h0000, 8'h90, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h20, 80'h0, 8'd64, 2'd2, 1'b0, 8'd1};
        vt[12] = '{24'h400302, 2'd1, 16'h0000, 8'h90, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h20, 80'h0, 8'd64, 2'd2, 1'b0, 8'd2};
        vt[13] = '{24'h420000, 2'd3, 16'h0000, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, EXP_CAL, 8'd80, 2'd2, 1'b0, 8'd2};
        vt[14] = '{24'h410000, 2'd1, 16'h0000, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, EXP_CAL, 8'd80, 2'd2, 1'b0, 8'd2};

        step();
        do_reset();
        chk("rst_buf", TX_BUFFER, '0);
        chk("rst_bits", TX_BIT_TOTAL, 8'd0);
        chk("rst_done", CMD_DONE, 1'b0);
        chk("rst_rumble", RUMBLE, 2'd0);
        chk("rst_need", NEED_ORIGIN, 1'b1);
        chk("rst_err", ERR_COUNT, 8'd0);

        for (int i = 0; i < 15; i++) begin
            set_inputs(vt[i].btn, vt[i].jx, vt[i].jy, vt[i].cx, vt[i].cy, vt[i].lt, vt[i].rt);
            issue(vt[i].cmd, vt[i].nb);
            chk($sformatf("vec%0d_buf", i), TX_BUFFER, {vt[i].resp, 16'h0000});
            chk($sformatf("vec%0d_bits", i), TX_BIT_TOTAL, vt[i].bits);
            chk($sformatf("vec%0d_done", i), CMD_DONE, 1'b1);
            chk($sformatf("vec%0d_rumble", i), RUMBLE, vt[i].rum);
            chk($sformatf("vec%0d_need", i), NEED_ORIGIN, vt[i].need);
            chk($sformatf("vec%0d_err", i), ERR_COUNT, vt[i].err);
            release_tx();
            chk($sformatf("vec%0d_done_fall", i), CMD_DONE, 1'b0);
        end

        // Timeout with a strobe dropped mid-hold
        do_reset();
        set_inputs(16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        issue(24'h000000, 2'd1);
        hold_phase(99, 3, cnt);
        chk("tmo_len", cnt, TMO);
        chk("tmo_err", ERR_COUNT, 8'd1);
        chk("tmo_done", CMD_DONE, 1'b0);
        chk("tmo_buf_keep", TX_BUFFER, {24'h090030, 72'h0});

        // Strobe during DECODE is dropped; the latched command is kept
        COMMAND = 24'h000000; CMD_BYTES = 2'd1; NEW_COMMAND = 1'b1;
        step();
        COMMAND = 24'h550000;
        step();
        NEW_COMMAND = 1'b0;
        chk("dec_drop_buf", TX_BUFFER, {24'h090030, 72'h0});
        chk("dec_drop_bits", TX_BIT_TOTAL, 8'd24);
        chk("dec_drop_err", ERR_COUNT, 8'd2);
        release_tx();

        // Reset while responding
        set_inputs(16'h0100, 8'h90, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h20);
        issue(24'h400302, 2'd3);
        release_tx();
        issue(24'h410000, 2'd1);
        release_tx();
        chk("pre_rst_need", NEED_ORIGIN, 1'b0);
        issue(24'h000000, 2'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("resp_rst_buf", TX_BUFFER, '0);
        chk("resp_rst_bits", TX_BIT_TOTAL, 8'd0);
        chk("resp_rst_done", CMD_DONE, 1'b0);
        chk("resp_rst_rumble", RUMBLE, 2'd0);
        chk("resp_rst_need", NEED_ORIGIN, 1'b1);
        chk("resp_rst_err", ERR_COUNT, 8'd0);
        issue(24'h400301, 2'd3);
        chk("post_rst_buf", TX_BUFFER, {64'h2180_9011_2233_C020, 32'h0});
        release_tx();

        // Random commands against the model
        do_reset();
        model_reset();
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:             op = 8'h00;
                1:             op = 8'hFF;
                2, 3, 4, 5:    op = 8'h40;
                6:             op = 8'h41;
                7:             op = 8'h42;
                default:       op = 8'($urandom);
            endcase
            nb = 2'($urandom_range(0, 3));
            if (op == 8'h40 && $urandom_range(0, 3) != 0) nb = 2'd3;
            mode = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cmd  = {op, mode, 8'($urandom)};
            btn = 16'($urandom);
            jx = 8'($urandom); jy = 8'($urandom); cx = 8'($urandom);
            cy = 8'($urandom); lt = 8'($urandom); rt = 8'($urandom);
            set_inputs(btn, jx, jy, cx, cy, lt, rt);
            issue(cmd, nb);
            model_apply(cmd, nb, btn, jx, jy, cx, cy, lt, rt, eresp, ebits);
            chk("rnd_buf", TX_BUFFER, {eresp, 16'h0000});
            chk("rnd_bits", TX_BIT_TOTAL, ebits);
            chk("rnd_done", CMD_DONE, 1'b1);
            chk("rnd_rumble", RUMBLE, m_rum);
            chk("rnd_need", NEED_ORIGIN, m_need);
            chk("rnd_err", ERR_COUNT, m_err);
            k   = $urandom_range(1, 10);
            lim = (k < TMO) ? k : TMO;
            j   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lim) : 0;
            hold_phase(k, j, cnt);
            if (j != 0 && m_err != 8'd255) m_err++;
            chk("rnd_hold_len", cnt, lim);
            chk("rnd_hold_err", ERR_COUNT, m_err);
            chk("rnd_buf_keep", TX_BUFFER, {eresp, 16'h0000});
            if (k > TMO) release_tx();
        end

        // Error counter saturation
        set_inputs(16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 260; i++) begin
            issue(24'h550000, 2'd1);
            model_apply(24'h550000, 2'd1, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, eresp, ebits);
            release_tx();
        end
        chk("err_sat", ERR_COUNT, 8'hFF);
        chk("err_sat_model", ERR_COUNT, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
